// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
package fwd_pkg;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam int SEL_RF = 0;

    function automatic int sel_width(input int stages);
        return $clog2(stages + 1);
    endfunction

endpackage

// File: rtl/fwd_prio_sel.sv
// Single-operand bypass select with nearest-stage priority.
module fwd_prio_sel
    import fwd_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int FWD_STAGES = 2,
    parameter int SEL_W      = sel_width(FWD_STAGES)
) (
    input  logic [REG_W-1:0]            src,
    input  logic [FWD_STAGES*REG_W-1:0] st_rd,
    input  logic [FWD_STAGES-1:0]       st_we,
    output logic [SEL_W-1:0]            sel
);

    // Walk from the oldest stage down so the youngest match is written last.
    always_comb begin
        sel = SEL_W'(SEL_RF);
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (st_we[k] && (src != '0) &&
                (st_rd[k*REG_W +: REG_W] == src)) begin
                sel = SEL_W'(k + 1);
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage bypass selects plus load-use stall FSM with multi-cycle bubbles.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16,
    parameter int SEL_W      = sel_width(FWD_STAGES)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_SRC*REG_W-1:0]    ex_src,
    input  logic [FWD_STAGES*REG_W-1:0] st_rd,
    input  logic [FWD_STAGES-1:0]       st_we,
    input  logic [NUM_SRC*REG_W-1:0]    id_src,
    input  logic [NUM_SRC-1:0]          id_src_used,
    input  logic                        id_valid,
    input  logic [REG_W-1:0]            idex_rd,
    input  logic                        idex_memread,
    input  logic                        flush,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
    output logic                        stall,
    output logic                        bubble,
    output logic [CNT_W-1:0]            stall_cnt
);

    localparam int REM_W = $clog2(LOAD_LAT + 1);

    state_t           state;
    logic [REM_W-1:0] rem;
    logic             haz;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_prio_sel #(
            .REG_W     (REG_W),
            .FWD_STAGES(FWD_STAGES),
            .SEL_W     (SEL_W)
        ) u_sel (
            .src  (ex_src[i*REG_W +: REG_W]),
            .st_rd(st_rd),
            .st_we(st_we),
            .sel  (fwd_sel[i*SEL_W +: SEL_W])
        );
    end

    always_comb begin
        haz = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_used[i] && (id_src[i*REG_W +: REG_W] == idex_rd)) begin
                haz = 1'b1;
            end
        end
        haz = haz & id_valid & idex_memread & (idex_rd != '0);
    end

    // A redirect always wins over the load-use hold.
    always_comb begin
        if (state == HOLD) begin
            stall = ~flush;
        end else begin
            stall = haz & ~flush;
        end
        bubble = stall;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            stall_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (haz && !flush && (LOAD_LAT > 1)) begin
                        state <= HOLD;
                        rem   <= REM_W'(LOAD_LAT - 1);
                    end
                end
                HOLD: begin
                    if (flush || (rem == REM_W'(1))) begin
                        state <= IDLE;
                        rem   <= '0;
                    end else begin
                        rem <= rem - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    rem   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed checks of bypass priority, load-use bubbles, flush and counter saturation.
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] ex_src;
    logic [9:0] st_rd;
    logic [1:0] st_we;
    logic [9:0] id_src;
    logic [1:0] id_src_used;
    logic       id_valid;
    logic [4:0] idex_rd;
    logic       idex_memread;
    logic       flush;

    logic [3:0]  fs1, fs3, fsc;
    logic        st1, st3, stc, bb1, bb3, bbc;
    logic [15:0] cnt1, cnt3;
    logic [1:0]  cntc;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(.LOAD_LAT(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .ex_src(ex_src), .st_rd(st_rd),
        .st_we(st_we), .id_src(id_src), .id_src_used(id_src_used),
        .id_valid(id_valid), .idex_rd(idex_rd),
        .idex_memread(idex_memread), .flush(flush),
        .fwd_sel(fs1), .stall(st1), .bubble(bb1), .stall_cnt(cnt1)
    );

    fwd_hazard_unit #(.LOAD_LAT(3)) u_l3 (
        .clk(clk), .rst_n(rst_n), .ex_src(ex_src), .st_rd(st_rd),
        .st_we(st_we), .id_src(id_src), .id_src_used(id_src_used),
        .id_valid(id_valid), .idex_rd(idex_rd),
        .idex_memread(idex_memread), .flush(flush),
        .fwd_sel(fs3), .stall(st3), .bubble(bb3), .stall_cnt(cnt3)
    );

    fwd_hazard_unit #(.LOAD_LAT(3), .CNT_W(2)) u_c2 (
        .clk(clk), .rst_n(rst_n), .ex_src(ex_src), .st_rd(st_rd),
        .st_we(st_we), .id_src(id_src), .id_src_used(id_src_used),
        .id_valid(id_valid), .idex_rd(idex_rd),
        .idex_memread(idex_memread), .flush(flush),
        .fwd_sel(fsc), .stall(stc), .bubble(bbc), .stall_cnt(cntc)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_haz(input logic on, input logic [1:0] used);
        id_valid     = on;
        idex_memread = on;
        idex_rd      = on ? 5'd3 : 5'd0;
        id_src       = on ? {5'd9, 5'd3} : 10'd0;
        id_src_used  = used;
    endtask

    initial begin
        rst_n = 1'b0;
        ex_src = '0; st_rd = '0; st_we = '0;
        flush = 1'b0;
        set_haz(1'b0, 2'b00);
        tick(); tick();
        rst_n = 1'b1;
        #1;
        check("rst_cnt1", cnt1, 0);
        check("rst_cnt3", cnt3, 0);
        check("rst_cntc", cntc, 0);
        check("rst_stall", st1, 0);
        check("rst_fwd", fs1, 0);

        // both stages hold r8: EX/MEM must win
        st_rd = {5'd8, 5'd8}; st_we = 2'b11; ex_src = {5'd0, 5'd8};
        #1;
        check("fwd_prio_rs", fs1[1:0], 1);
        check("fwd_prio_rt", fs1[3:2], 0);
        check("fwd_prio_rs_l3", fs3[1:0], 1);
        st_we = 2'b10;
        #1;
        check("fwd_memwb_rs", fs1[1:0], 2);
        st_we = 2'b00;
        #1;
        check("fwd_none_rs", fs1[1:0], 0);

        st_rd = {5'd5, 5'd0}; st_we = 2'b11; ex_src = {5'd5, 5'd0};
        #1;
        check("fwd_r0_rs", fs1[1:0], 0);
        check("fwd_memwb_rt", fs1[3:2], 2);
        st_we = 2'b10;
        #1;
        check("fwd_memwb_rt2", fs1[3:2], 2);
        st_rd = {5'd5, 5'd5}; st_we = 2'b11;
        #1;
        check("fwd_exmem_rt", fs1[3:2], 1);

        set_haz(1'b1, 2'b00);
        #1;
        check("haz_unused", st1, 0);
        set_haz(1'b1, 2'b10);
        #1;
        check("haz_rt_nomatch", st1, 0);
        id_valid = 1'b0; id_src_used = 2'b01;
        #1;
        check("haz_invalid", st1, 0);
        set_haz(1'b1, 2'b01);
        #1;
        check("haz_l1_stall", st1, 1);
        check("haz_l1_bubble", bb1, 1);
        check("haz_l3_stall_c1", st3, 1);
        tick();
        set_haz(1'b0, 2'b00);
        #1;
        check("haz_l1_release", st1, 0);
        check("haz_l1_cnt", cnt1, 1);
        check("haz_l3_stall_c2", st3, 1);
        check("haz_l3_bubble_c2", bb3, 1);
        tick();
        check("haz_l3_stall_c3", st3, 1);
        tick();
        check("haz_l3_release", st3, 0);
        check("haz_l3_cnt", cnt3, 3);
        check("haz_c2_cnt", cntc, 3);
        tick();
        check("haz_l3_cnt_hold", cnt3, 3);

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("rst2_cnt3", cnt3, 0);
        set_haz(1'b1, 2'b01);
        tick();
        set_haz(1'b0, 2'b00);
        flush = 1'b1;
        #1;
        check("flush_stall", st3, 0);
        check("flush_bubble", bb3, 0);
        tick();
        flush = 1'b0;
        #1;
        check("flush_idle", st3, 0);
        check("flush_cnt", cnt3, 1);
        tick();
        check("flush_cnt_hold", cnt3, 1);

        set_haz(1'b1, 2'b01);
        flush = 1'b1;
        #1;
        check("flush_mask_l1", st1, 0);
        check("flush_mask_l3", st3, 0);
        tick();
        flush = 1'b0;
        set_haz(1'b0, 2'b00);
        #1;
        check("flush_mask_cnt", cnt3, 1);
        check("flush_mask_state", st3, 0);

        // c2 already at 1; three more stalls must pin it at 3
        set_haz(1'b1, 2'b01);
        tick();
        set_haz(1'b0, 2'b00);
        tick(); tick();
        check("sat_c2_cnt", cntc, 3);
        check("sat_l3_cnt", cnt3, 4);
        tick();
        check("sat_c2_idle", stc, 0);

        set_haz(1'b1, 2'b01);
        tick();
        set_haz(1'b0, 2'b00);
        #1;
        check("rst_hold_stall", stc, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        check("rst_hold_idle", stc, 0);
        check("rst_hold_cnt", cntc, 0);
        tick();
        check("rst_hold_stay", stc, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
